// File: rtl/hamming_serial_rx.sv
// Serial Hamming(12,8) receiver: shifts in a codeword one bit per cycle, corrects
// single-bit errors, flags syndromes 13..15 and presents the byte on a valid/ready port.
module hamming_serial_rx #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_bit,
    input  logic             rx_valid,
    input  logic             rx_sof,
    output logic             rx_ready,
    output logic [7:0]       data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             corrected,
    output logic             uncorr,
    output logic [3:0]       syndrome,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] uncorr_count
);

    typedef enum logic [1:0] {
        SHIFT,
        CHECK,
        HOLD
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        ready_en;
    logic [3:0]  cnt;
    logic [11:0] sreg;
    logic        accept;
    logic [3:0]  syn;
    logic        syn_corr;
    logic        syn_uncorr;
    logic [11:0] fixed;

    // ready_en keeps rx_ready low during the cycle reset is applied
    assign rx_ready = ready_en && (state == SHIFT);
    assign accept   = rx_ready && rx_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SHIFT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            SHIFT: begin
                if (accept && !rx_sof && cnt == 4'd11) begin
                    next_state = CHECK;
                end
            end
            CHECK: next_state = HOLD;
            HOLD: begin
                if (data_valid && data_ready) begin
                    next_state = SHIFT;
                end
            end
            default: next_state = SHIFT;
        endcase
    end

    // sreg[i] holds codeword position i+1
    always_comb begin
        syn = '0;
        for (int p = 1; p <= 12; p++) begin
            if (sreg[p-1]) begin
                syn = syn ^ 4'(p);
            end
        end
        syn_corr   = (syn != 4'd0) && (syn <= 4'd12);
        syn_uncorr = (syn >= 4'd13);
        fixed      = sreg;
        if (syn_corr) begin
            fixed[syn - 4'd1] = ~sreg[syn - 4'd1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_en     <= 1'b0;
            cnt          <= '0;
            sreg         <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            corrected    <= 1'b0;
            uncorr       <= 1'b0;
            syndrome     <= '0;
            corr_count   <= '0;
            uncorr_count <= '0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                SHIFT: begin
                    if (accept) begin
                        if (rx_sof) begin
                            sreg <= {11'b0, rx_bit};
                            cnt  <= 4'd1;
                        end else begin
                            sreg[cnt] <= rx_bit;
                            cnt       <= cnt + 4'd1;
                        end
                    end
                end
                CHECK: begin
                    syndrome   <= syn;
                    corrected  <= syn_corr;
                    uncorr     <= syn_uncorr;
                    data_valid <= 1'b1;
                    data_out   <= {fixed[11], fixed[10], fixed[9], fixed[8],
                                   fixed[6], fixed[5], fixed[4], fixed[2]};
                    if (syn_corr && corr_count != '1) begin
                        corr_count <= corr_count + CNT_W'(1);
                    end
                    if (syn_uncorr && uncorr_count != '1) begin
                        uncorr_count <= uncorr_count + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (data_valid && data_ready) begin
                        data_valid <= 1'b0;
                        cnt        <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Scoreboard bench for hamming_serial_rx: a Hamming(12,8) encoder/decoder model
// queues expected words, a negedge monitor compares them on each output handshake.
module tb_hamming_serial_rx;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             rx_bit;
    logic             rx_valid;
    logic             rx_sof;
    logic             rx_ready;
    logic [7:0]       data_out;
    logic             data_valid;
    logic             data_ready;
    logic             corrected;
    logic             uncorr;
    logic [3:0]       syndrome;
    logic [CNT_W-1:0] corr_count;
    logic [CNT_W-1:0] uncorr_count;

    typedef struct {
        logic [7:0] data;
        logic [3:0] syn;
        logic       corr;
        logic       unc;
        int         cc;
        int         uc;
    } exp_t;

    exp_t sbq[$];
    int   compareCount = 0;
    int   failCount    = 0;
    int   modelCorr    = 0;
    int   modelUncorr  = 0;

    hamming_serial_rx #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_bit       (rx_bit),
        .rx_valid     (rx_valid),
        .rx_sof       (rx_sof),
        .rx_ready     (rx_ready),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .corrected    (corrected),
        .uncorr       (uncorr),
        .syndrome     (syndrome),
        .corr_count   (corr_count),
        .uncorr_count (uncorr_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [12:1] posMask(input int p);
        logic [12:1] m;
        m    = '0;
        m[p] = 1'b1;
        return m;
    endfunction

    function automatic logic [12:1] encodeWord(input logic [7:0] d);
        logic [12:1] w;
        logic        par;
        w = '0;
        {w[12], w[11], w[10], w[9], w[7], w[6], w[5], w[3]} = d;
        for (int k = 0; k < 4; k++) begin
            par = 1'b0;
            for (int i = 1; i <= 12; i++) begin
                if (((i >> k) & 1) == 1) par = par ^ w[i];
            end
            w[1 << k] = par;
        end
        return w;
    endfunction

    // Inputs change 2 ns after the rising edge so the monitor can sample on the falling edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic sendBit(input logic b, input logic sof);
        int budget;
        rx_bit   = b;
        rx_sof   = sof;
        rx_valid = 1'b1;
        budget   = 100;
        while (!rx_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) checkOutput("rx_ready_timeout", 32'(rx_ready), 32'd1);
        tick();
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
    endtask

    // Drives a full codeword with err inverted positions and queues the model's answer
    task automatic applyStimulus(input logic [7:0] d, input logic [12:1] err, input logic useSof);
        logic [12:1] rec;
        logic [12:1] fix;
        logic [3:0]  s;
        exp_t        e;
        rec = encodeWord(d) ^ err;
        s   = '0;
        for (int i = 1; i <= 12; i++) begin
            if (rec[i]) s = s ^ 4'(i);
        end
        fix    = rec;
        e.corr = (s >= 4'd1 && s <= 4'd12);
        e.unc  = (s >= 4'd13);
        if (e.corr) fix[s] = ~fix[s];
        if (e.corr && modelCorr < CNT_MAX) modelCorr++;
        if (e.unc && modelUncorr < CNT_MAX) modelUncorr++;
        e.data = {fix[12], fix[11], fix[10], fix[9], fix[7], fix[6], fix[5], fix[3]};
        e.syn  = s;
        e.cc   = modelCorr;
        e.uc   = modelUncorr;
        sbq.push_back(e);
        for (int i = 1; i <= 12; i++) begin
            sendBit(rec[i], useSof && (i == 1));
        end
    endtask

    task automatic waitDrain();
        int budget;
        budget = 200;
        while (sbq.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        checkOutput("sb_drain", 32'(sbq.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && data_valid && data_ready) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected_word", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                checkOutput("data_out", 32'(data_out), 32'(e.data));
                checkOutput("syndrome", 32'(syndrome), 32'(e.syn));
                checkOutput("corrected", 32'(corrected), 32'(e.corr));
                checkOutput("uncorr", 32'(uncorr), 32'(e.unc));
                checkOutput("corr_count", 32'(corr_count), 32'(e.cc));
                checkOutput("uncorr_count", 32'(uncorr_count), 32'(e.uc));
            end
        end
    end

    initial begin
        logic [7:0] heldData;
        logic [3:0] heldSyn;
        int         budget;

        rst_n      = 1'b0;
        rx_bit     = 1'b0;
        rx_valid   = 1'b1;
        rx_sof     = 1'b1;
        data_ready = 1'b1;
        repeat (3) tick();
        checkOutput("reset_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("reset_data_valid", 32'(data_valid), 32'd0);
        checkOutput("reset_data_out", 32'(data_out), 32'd0);
        checkOutput("reset_syndrome", 32'(syndrome), 32'd0);
        checkOutput("reset_flags", 32'({corrected, uncorr}), 32'd0);
        checkOutput("reset_counts", 32'({corr_count, uncorr_count}), 32'd0);
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        rst_n    = 1'b1;
        tick();
        checkOutput("ready_after_reset", 32'(rx_ready), 32'd1);

        $display("[TB] clean word and latency");
        applyStimulus(8'hA5, '0, 1'b1);
        checkOutput("latency_valid_n", 32'(data_valid), 32'd0);
        checkOutput("check_rx_ready", 32'(rx_ready), 32'd0);
        tick();
        checkOutput("latency_valid_n1", 32'(data_valid), 32'd1);
        waitDrain();

        $display("[TB] single, uncorrectable and parity-bit errors");
        applyStimulus(8'hA5, posMask(6), 1'b1);
        applyStimulus(8'hA5, posMask(4) | posMask(9), 1'b1);
        applyStimulus(8'hA5, posMask(1) | posMask(4) | posMask(8), 1'b1);
        applyStimulus(8'h3C, posMask(1) | posMask(2) | posMask(4) | posMask(8), 1'b0);
        applyStimulus(8'hFF, posMask(12), 1'b1);
        applyStimulus(8'h00, posMask(8), 1'b0);
        waitDrain();

        $display("[TB] backpressure");
        data_ready = 1'b0;
        applyStimulus(8'h5A, posMask(10), 1'b1);
        budget = 20;
        while (!data_valid && budget > 0) begin
            tick();
            budget--;
        end
        checkOutput("bp_valid", 32'(data_valid), 32'd1);
        heldData = data_out;
        heldSyn  = syndrome;
        for (int c = 0; c < 5; c++) begin
            rx_valid = 1'b1;
            rx_sof   = 1'b1;
            rx_bit   = 1'b1;
            tick();
            checkOutput("bp_rx_ready", 32'(rx_ready), 32'd0);
            checkOutput("bp_hold_valid", 32'(data_valid), 32'd1);
            checkOutput("bp_hold_data", 32'(data_out), 32'(heldData));
            checkOutput("bp_hold_syn", 32'(heldSyn), 32'd10);
            checkOutput("bp_hold_syn_stable", 32'(syndrome), 32'(heldSyn));
        end
        rx_valid   = 1'b0;
        rx_sof     = 1'b0;
        data_ready = 1'b1;
        waitDrain();
        applyStimulus(8'hC3, '0, 1'b0);
        waitDrain();

        $display("[TB] realign");
        for (int i = 0; i < 7; i++) sendBit(1'(i), i == 0);
        applyStimulus(8'h3C, '0, 1'b1);
        waitDrain();

        $display("[TB] reset mid-frame and saturation");
        for (int i = 0; i < 5; i++) sendBit(1'b1, i == 0);
        rst_n = 1'b0;
        tick();
        modelCorr   = 0;
        modelUncorr = 0;
        checkOutput("midreset_counts", 32'({corr_count, uncorr_count}), 32'd0);
        checkOutput("midreset_valid", 32'(data_valid), 32'd0);
        checkOutput("midreset_rx_ready", 32'(rx_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        applyStimulus(8'h96, '0, 1'b0);
        for (int f = 0; f < 5; f++) begin
            applyStimulus(8'($urandom_range(0, 255)), posMask(f + 2), 1'b1);
        end
        waitDrain();
        checkOutput("sat_corr_count", 32'(corr_count), 32'(CNT_MAX));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
